// File: rtl/m72_pkg.sv
// Shared types and constants for the ioctl download to SDRAM word path.
package m72_pkg;

    localparam int IOCTL_FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic [24:1] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } ioctl_word_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } issue_state_t;

    // Sum of the byte lanes actually carried by a word (disabled lanes count as zero).
    function automatic logic [15:0] word_byte_sum(input ioctl_word_t w);
        logic [15:0] s;
        s = '0;
        if (w.be[0]) s = s + {8'h00, w.data[7:0]};
        if (w.be[1]) s = s + {8'h00, w.data[15:8]};
        return s;
    endfunction

endpackage

// File: rtl/sdr_word_fifo.sv
// Small synchronous word FIFO with occupancy count; the head is registered by the consumer.
module sdr_word_fifo
    import m72_pkg::*;
#(
    parameter int DEPTH = IOCTL_FIFO_DEPTH_DEF
) (
    input  logic                   clk_sys,
    input  logic                   srst,
    input  logic                   push,
    input  ioctl_word_t            push_data,
    input  logic                   pop,
    output ioctl_word_t            head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    ioctl_word_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is refused so a stored entry is never overwritten.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk_sys) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/ioctl_sdr_packer.sv
// Packs ioctl download bytes into 16-bit SDRAM word writes behind a toggle handshake.
// Optional IOCTL_PACK_CHECKSUM_EN adds a 16-bit sum of all accepted bytes.
module ioctl_sdr_packer
    import m72_pkg::*;
#(
    parameter int FIFO_DEPTH = IOCTL_FIFO_DEPTH_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [24:1] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic        load_done,
    output logic        overflow
`ifdef IOCTL_PACK_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);

    logic         downl_reg;
    logic         fall_seen_reg;
    logic         pend_valid_reg;
    logic [24:1]  pend_addr_reg;
    logic [7:0]   pend_data_reg;
    logic         defer_valid_reg;
    logic [24:0]  defer_addr_reg;
    logic [7:0]   defer_data_reg;
    logic         stage_valid_reg;
    ioctl_word_t  stage_word_reg;
    issue_state_t state_reg;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    ioctl_word_t   fifo_head;
    logic [CW-1:0] fifo_count;

    logic         rise_det;
    logic         fall_det;
    logic         byte_valid;
    logic [24:0]  byte_addr;
    logic [7:0]   byte_data;
    logic         drained;

    assign rise_det = ioctl_downl & ~downl_reg;
    assign fall_det = ~ioctl_downl & downl_reg;

    // A byte displaced by a pending flush is replayed one cycle later as if freshly strobed.
    assign byte_valid = defer_valid_reg | ioctl_wr;
    assign byte_addr  = defer_valid_reg ? defer_addr_reg : ioctl_addr;
    assign byte_data  = defer_valid_reg ? defer_data_reg : ioctl_dout;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            downl_reg       <= 1'b0;
            fall_seen_reg   <= 1'b0;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            pend_data_reg   <= '0;
            defer_valid_reg <= 1'b0;
            defer_addr_reg  <= '0;
            defer_data_reg  <= '0;
            stage_valid_reg <= 1'b0;
            stage_word_reg  <= '0;
        end else begin
            downl_reg       <= ioctl_downl;
            stage_valid_reg <= 1'b0;
            defer_valid_reg <= 1'b0;
            if (rise_det)      fall_seen_reg <= 1'b0;
            else if (fall_det) fall_seen_reg <= 1'b1;

            if (byte_valid) begin
                if (pend_valid_reg && !(byte_addr[0] && byte_addr[24:1] == pend_addr_reg)) begin
                    stage_valid_reg <= 1'b1;
                    stage_word_reg  <= '{addr: pend_addr_reg, data: {8'h00, pend_data_reg}, be: 2'b01};
                    pend_valid_reg  <= 1'b0;
                    defer_valid_reg <= 1'b1;
                    defer_addr_reg  <= byte_addr;
                    defer_data_reg  <= byte_data;
                end else if (byte_addr[0]) begin
                    stage_valid_reg <= 1'b1;
                    stage_word_reg  <= '{addr: byte_addr[24:1],
                                         data: {byte_data, pend_valid_reg ? pend_data_reg : 8'h00},
                                         be:   {1'b1, pend_valid_reg}};
                    pend_valid_reg  <= 1'b0;
                end else begin
                    pend_valid_reg <= 1'b1;
                    pend_addr_reg  <= byte_addr[24:1];
                    pend_data_reg  <= byte_data;
                end
            end else if (pend_valid_reg && !ioctl_downl && (fall_det || fall_seen_reg)) begin
                stage_valid_reg <= 1'b1;
                stage_word_reg  <= '{addr: pend_addr_reg, data: {8'h00, pend_data_reg}, be: 2'b01};
                pend_valid_reg  <= 1'b0;
            end
        end
    end

    assign fifo_push = stage_valid_reg & ~fifo_full;
    assign fifo_pop  = (state_reg == IDLE) & ~fifo_empty;

    sdr_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .srst      (reset),
        .push      (fifo_push),
        .push_data (stage_word_reg),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ioctl_wait = (fifo_count >= WAIT_LEVEL);

    // Resetting sdr_req to the live sdr_ack abandons any write still in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= IDLE;
            sdr_req   <= sdr_ack;
            sdr_addr  <= '0;
            sdr_data  <= '0;
            sdr_be    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        sdr_addr  <= fifo_head.addr;
                        sdr_data  <= fifo_head.data;
                        sdr_be    <= fifo_head.be;
                        sdr_req   <= ~sdr_req;
                        state_reg <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdr_ack == sdr_req) state_reg <= IDLE;
                end
            endcase
        end
    end

    assign drained = !ioctl_downl && fall_seen_reg && !pend_valid_reg && !defer_valid_reg &&
                     !stage_valid_reg && fifo_empty && (state_reg == IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            overflow  <= 1'b0;
            load_done <= 1'b0;
        end else if (rise_det) begin
            overflow  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            if (stage_valid_reg && fifo_full) overflow <= 1'b1;
            if (drained) load_done <= 1'b1;
        end
    end

`ifdef IOCTL_PACK_CHECKSUM_EN
    logic [15:0] checksum_reg;

    always_ff @(posedge clk_sys) begin
        if (reset || rise_det) checksum_reg <= '0;
        else if (fifo_push)    checksum_reg <= checksum_reg + word_byte_sum(stage_word_reg);
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: doc/ioctl_sdr_packer.md
IOCTL_SDR_PACKER -- requirements
Module: ioctl_sdr_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), word FIFO entries.
REQ-002 SHALL have port clk_sys, input, 1 bit; the single clock, 32 MHz system clock.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port ioctl_downl, input, 1 bit; download active.
REQ-005 SHALL have port ioctl_wr, input, 1 bit; one-cycle byte strobe, spaced ≥4 cycles apart.
REQ-006 SHALL have port ioctl_addr, input, 25 bits; byte address.
REQ-007 SHALL have port ioctl_dout, input, 8 bits; byte data.
REQ-008 SHALL have port ioctl_wait, output, 1 bit; backpressure to data_io.
REQ-009 SHALL have ports sdr_addr (24 bits, [24:1]), sdr_data (16 bits), sdr_be (2 bits), all outputs; word write to SDRAM.
REQ-010 SHALL have port sdr_req, output, 1 bit; toggle request.
REQ-011 SHALL have port sdr_ack, input, 1 bit; completion when equal to sdr_req.
REQ-012 SHALL have port load_done, output, 1 bit; high once the download has fully drained.
REQ-013 SHALL have port overflow, output, 1 bit; sticky, a byte was dropped.

Function
REQ-014 SHALL pack bytes into 16-bit words: even address to data[7:0] with be[0]; odd address to data[15:8] with be[1].
REQ-015 SHALL hold an even byte in a pending register; an odd byte at pending address+1 SHALL push the word {addr[24:1], data, be=2'b11} in the cycle after the strobe.
REQ-016 SHALL, on an odd byte with no matching pending byte, push a word with be=2'b10.
REQ-017 SHALL, on a new byte whose address is not pending+1, first push the pending word with be=2'b01, then handle the new byte in the following cycle.
REQ-018 SHALL, on the falling edge of ioctl_downl, push any pending byte with be=2'b01.
REQ-019 SHALL use an issue FSM with states IDLE and WAIT_ACK.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head, drive sdr_addr/data/be, toggle sdr_req and enter WAIT_ACK; sdr_req therefore toggles 2 cycles after the completing strobe.
REQ-021 SHALL, in WAIT_ACK, hold sdr_addr/data/be stable and return to IDLE on the cycle sdr_ack==sdr_req; the next toggle is allowed in the following cycle.
REQ-022 SHALL assert ioctl_wait while FIFO occupancy ≥ FIFO_DEPTH-1.
REQ-023 SHALL, when a push is needed with the FIFO full, drop that word and set overflow; an existing FIFO entry is never overwritten.
REQ-024 SHALL clear overflow and load_done on the rising edge of ioctl_downl.
REQ-025 SHALL set load_done when ioctl_downl is low, a fall has been seen, the pending register is empty, the FIFO is empty and the FSM is in IDLE.
REQ-026 SHALL give priority to a FIFO push over a pop when both occur in the same cycle; both execute and occupancy is unchanged.

Reset
REQ-027 SHALL, on reset, empty the FIFO and the pending register and set FSM=IDLE.
REQ-028 SHALL, on reset, drive sdr_addr=0, sdr_data=0, sdr_be=0, ioctl_wait=0, load_done=0 and overflow=0.
REQ-029 SHALL, on reset, load sdr_req with the current sdr_ack, so no request is outstanding.
REQ-030 SHALL, on reset mid-transfer, abandon the outstanding write and SHALL NOT re-issue it.

Configuration
REQ-031 SHALL, with IOCTL_PACK_CHECKSUM_EN defined, add output checksum [15:0]: the modulo-2^16 sum of every accepted byte, cleared on reset and on the ioctl_downl rise; dropped bytes are excluded.
REQ-032 SHALL, without IOCTL_PACK_CHECKSUM_EN, have no checksum port or logic.

Structure
REQ-033 SHALL place the FIFO entry typedef ioctl_word_t {addr[24:1], data[15:0], be[1:0]} and the constant IOCTL_FIFO_DEPTH_DEF=4 in m72_pkg.
REQ-034 SHALL instantiate a single sub-module, sdr_word_fifo (synchronous FIFO with count output), for the FIFO storage.

Verification
REQ-035 SHALL verify: bytes 0x11@0x0, 0x22@0x1 -> one write, addr 0, data 0x2211, be 11; sdr_req toggles 2 cycles after the second strobe.
REQ-036 SHALL verify: 0xAA@0x10, then 0xBB@0x20 -> writes {addr 0x8, 0x00AA, be 01}, then pending 0xBB flushed on ioctl_downl fall as {0x10, 0x00BB, be 01}.
REQ-037 SHALL verify: 0x5C@0x3 alone -> {addr 1, data 0x5C00, be 10}.
REQ-038 SHALL verify: sdr_ack held 100 cycles and 10 words streamed, FIFO_DEPTH=4 -> ioctl_wait asserted at occupancy 3; a forced strobe at full sets overflow and the word is absent from the write sequence.
REQ-039 SHALL verify: reset during WAIT_ACK -> sdr_req==sdr_ack next cycle, FIFO empty, no further toggle; a new download then writes normally.
REQ-040 SHALL verify, with IOCTL_PACK_CHECKSUM_EN: bytes 0xFF,0xFF,0x02 -> checksum 0x0200; load_done=1 after drain.
